// File: rtl/elastic_io_wrapper.sv
`timescale 1ns/1ps
// Elastic wrapper around a one-argument kernel: registered FWFT input and output FIFOs.
// Kernel issue is throttled by output-FIFO credits, so every returned result has a slot.
module elastic_io_wrapper #(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned IN_DEPTH  = 2,
    parameter int unsigned OUT_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               arg0,
    input  logic                           arg0_valid,
    output logic                           arg0_ready,
    output logic [WIDTH-1:0]               k_arg0,
    output logic                           k_arg0_valid,
    input  logic                           k_arg0_ready,
    input  logic [WIDTH-1:0]               k_out0,
    input  logic                           k_out0_valid,
    output logic                           k_out0_ready,
    output logic [WIDTH-1:0]               out0,
    output logic                           out0_valid,
    input  logic                           out0_ready,
    output logic [$clog2(OUT_DEPTH+1)-1:0] inflight,
    output logic                           proto_err
);
    localparam int unsigned IPW = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
    localparam int unsigned OPW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int unsigned ICW = $clog2(IN_DEPTH + 1);
    localparam int unsigned OCW = $clog2(OUT_DEPTH + 1);

    // Storage is rounded up to a power of two so pointer width always matches the index.
    logic [WIDTH-1:0] r_in_mem  [2**IPW];
    logic [WIDTH-1:0] r_out_mem [2**OPW];
    logic [IPW-1:0]   r_in_wr, r_in_rd;
    logic [OPW-1:0]   r_out_wr, r_out_rd;
    logic [ICW-1:0]   r_in_cnt;
    logic [OCW-1:0]   r_out_cnt;
    logic [OCW-1:0]   r_inflight;
    logic             r_proto_err;

    logic w_in_full, w_in_empty, w_out_full, w_out_empty, w_credit;
    logic w_in_push, w_in_pop, w_out_push, w_out_pop, w_stray;

    function automatic logic [IPW-1:0] in_next(input logic [IPW-1:0] p);
        return (p == IPW'(IN_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [OPW-1:0] out_next(input logic [OPW-1:0] p);
        return (p == OPW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_in_full   = (r_in_cnt == ICW'(IN_DEPTH));
        w_in_empty  = (r_in_cnt == '0);
        w_out_full  = (r_out_cnt == OCW'(OUT_DEPTH));
        w_out_empty = (r_out_cnt == '0);
        // Results still owed by the kernel reserve output slots just like stored results.
        w_credit    = (({1'b0, r_inflight} + {1'b0, r_out_cnt}) < (OCW+1)'(OUT_DEPTH));

        arg0_ready   = !rst && !w_in_full;
        k_arg0       = r_in_mem[r_in_rd];
        k_arg0_valid = !w_in_empty && w_credit;
        k_out0_ready = !rst && !w_out_full;
        out0         = r_out_mem[r_out_rd];
        out0_valid   = !w_out_empty;
        inflight     = r_inflight;
        proto_err    = r_proto_err;

        w_in_push  = arg0_valid && arg0_ready;
        w_in_pop   = k_arg0_valid && k_arg0_ready;
        w_stray    = k_out0_valid && (r_inflight == '0);
        w_out_push = k_out0_valid && k_out0_ready && !w_stray;
        w_out_pop  = out0_valid && out0_ready;
    end

    always_ff @(posedge clk) begin
        if (w_in_push) begin
            r_in_mem[r_in_wr] <= arg0;
        end
        if (w_out_push) begin
            r_out_mem[r_out_wr] <= k_out0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wr     <= '0;
            r_in_rd     <= '0;
            r_in_cnt    <= '0;
            r_out_wr    <= '0;
            r_out_rd    <= '0;
            r_out_cnt   <= '0;
            r_inflight  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_in_push) r_in_wr <= in_next(r_in_wr);
            if (w_in_pop)  r_in_rd <= in_next(r_in_rd);
            if (w_in_push && !w_in_pop)      r_in_cnt <= r_in_cnt + 1'b1;
            else if (!w_in_push && w_in_pop) r_in_cnt <= r_in_cnt - 1'b1;

            if (w_out_push) r_out_wr <= out_next(r_out_wr);
            if (w_out_pop)  r_out_rd <= out_next(r_out_rd);
            if (w_out_push && !w_out_pop)      r_out_cnt <= r_out_cnt + 1'b1;
            else if (!w_out_push && w_out_pop) r_out_cnt <= r_out_cnt - 1'b1;

            if (w_in_pop && !w_out_push)      r_inflight <= r_inflight + 1'b1;
            else if (!w_in_pop && w_out_push) r_inflight <= r_inflight - 1'b1;

            if (w_stray) r_proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_elastic_io_wrapper.sv
`timescale 1ns/1ps
// Scoreboard bench: default instance driven by directed scenarios, wide instance by a random stream.
module tb_elastic_io_wrapper;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // default instance
    logic [9:0] arg0 = '0, k_arg0, k_out0 = '0, out0;
    logic       arg0_valid = 1'b0, arg0_ready, k_arg0_valid, k_arg0_ready = 1'b1;
    logic       k_out0_valid = 1'b0, k_out0_ready, out0_valid, out0_ready = 1'b1;
    logic [1:0] inflight;
    logic       proto_err;

    // wide instance
    logic [31:0] b_arg0 = '0, b_k_arg0, b_k_out0 = '0, b_out0;
    logic        b_arg0_valid = 1'b0, b_arg0_ready, b_k_arg0_valid, b_k_arg0_ready = 1'b0;
    logic        b_k_out0_valid = 1'b0, b_k_out0_ready, b_out0_valid, b_out0_ready = 1'b0;
    logic [2:0]  b_inflight;
    logic        b_proto_err;

    elastic_io_wrapper u_dut_a (
        .clk(clk), .rst(rst),
        .arg0(arg0), .arg0_valid(arg0_valid), .arg0_ready(arg0_ready),
        .k_arg0(k_arg0), .k_arg0_valid(k_arg0_valid), .k_arg0_ready(k_arg0_ready),
        .k_out0(k_out0), .k_out0_valid(k_out0_valid), .k_out0_ready(k_out0_ready),
        .out0(out0), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .inflight(inflight), .proto_err(proto_err)
    );

    elastic_io_wrapper #(.WIDTH(32), .IN_DEPTH(1), .OUT_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .arg0(b_arg0), .arg0_valid(b_arg0_valid), .arg0_ready(b_arg0_ready),
        .k_arg0(b_k_arg0), .k_arg0_valid(b_k_arg0_valid), .k_arg0_ready(b_k_arg0_ready),
        .k_out0(b_k_out0), .k_out0_valid(b_k_out0_valid), .k_out0_ready(b_k_out0_ready),
        .out0(b_out0), .out0_valid(b_out0_valid), .out0_ready(b_out0_ready),
        .inflight(b_inflight), .proto_err(b_proto_err)
    );

    logic [9:0]  exp_a[$];
    logic [31:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // identity kernel for the default instance, one cycle of latency
    logic [9:0]  ka_q[$];
    logic        ka_hold = 1'b0, ka_inject = 1'b0;
    logic [9:0]  ka_inj_data = '0;
    logic        ka_arg_fire = 1'b0, ka_res_fire = 1'b0;
    logic [9:0]  ka_arg_data = '0;
    int unsigned ka_arg_xfers = 0;

    always @(negedge clk) begin
        ka_arg_fire = k_arg0_valid && k_arg0_ready;
        ka_arg_data = k_arg0;
        ka_res_fire = k_out0_valid && k_out0_ready && !ka_inject;
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            ka_q.delete();
        end else begin
            if (ka_res_fire && ka_q.size() > 0) void'(ka_q.pop_front());
            if (ka_arg_fire) begin
                ka_q.push_back(ka_arg_data);
                ka_arg_xfers++;
            end
        end
        ka_arg_fire  = 1'b0;
        ka_res_fire  = 1'b0;
        k_out0_valid = ka_inject || (ka_q.size() > 0 && !ka_hold);
        k_out0       = ka_inject ? ka_inj_data : ((ka_q.size() > 0) ? ka_q[0] : 10'h000);
    end

    // random identity kernel and sink for the wide instance
    logic [31:0] kb_q[$];
    logic        kb_arg_fire = 1'b0, kb_res_fire = 1'b0, kb_gate = 1'b0;
    logic [31:0] kb_arg_data = '0;
    int unsigned b_max_inflight = 0;

    always @(negedge clk) begin
        kb_arg_fire = b_k_arg0_valid && b_k_arg0_ready;
        kb_arg_data = b_k_arg0;
        kb_res_fire = b_k_out0_valid && b_k_out0_ready;
        if (b_inflight > b_max_inflight) b_max_inflight = b_inflight;
    end

    always @(posedge clk) begin
        #2;
        if (rst) begin
            kb_q.delete();
        end else begin
            if (kb_res_fire && kb_q.size() > 0) void'(kb_q.pop_front());
            if (kb_arg_fire) kb_q.push_back(kb_arg_data);
        end
        // a presented result stays put until it is taken
        if (!b_k_out0_valid || kb_res_fire) kb_gate = ($urandom_range(1) == 1);
        kb_arg_fire    = 1'b0;
        kb_res_fire    = 1'b0;
        b_k_out0_valid = kb_gate && (kb_q.size() > 0);
        b_k_out0       = (kb_q.size() > 0) ? kb_q[0] : 32'h0;
        b_k_arg0_ready = ($urandom_range(1) == 1);
        b_out0_ready   = ($urandom_range(1) == 1);
    end

    // monitors
    always @(negedge clk) begin
        if (!rst && out0_valid && out0_ready) begin
            if (exp_a.size() == 0) begin
                n_checks++;
                $display("FAIL out0_unexpected: got 0x%0h, expected no token", out0);
            end else begin
                check("out0_data", {22'h0, out0}, {22'h0, exp_a.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out0_valid && b_out0_ready) begin
            if (exp_b.size() == 0) begin
                n_checks++;
                $display("FAIL b_out0_unexpected: got 0x%0h, expected no token", b_out0);
            end else begin
                check("b_out0_data", b_out0, exp_b.pop_front());
            end
        end
    end

    task automatic push_a(input logic [9:0] d);
        int unsigned n;
        n = 0;
        arg0 = d;
        arg0_valid = 1'b1;
        @(negedge clk);
        while (!arg0_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        arg0_valid = 1'b0;
        if (n >= 200) begin
            n_checks++;
            $display("FAIL push_a_timeout: got arg0_ready=0, expected 1 within 200 cycles");
        end else begin
            exp_a.push_back(d);
        end
    endtask

    task automatic push_b(input logic [31:0] d);
        int unsigned n;
        n = 0;
        b_arg0 = d;
        b_arg0_valid = 1'b1;
        @(negedge clk);
        while (!b_arg0_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        b_arg0_valid = 1'b0;
        if (n >= 200) begin
            n_checks++;
            $display("FAIL push_b_timeout: got arg0_ready=0, expected 1 within 200 cycles");
        end else begin
            exp_b.push_back(d);
        end
    endtask

    task automatic drain_a(input string name);
        int unsigned n;
        n = 0;
        while ((exp_a.size() != 0 || inflight != 2'd0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_pending"}, exp_a.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned xfers0;
        int unsigned n;

        // reset holds everything idle while the clock runs
        #12;
        check("rst_arg0_ready",   arg0_ready,   0);
        check("rst_k_arg0_valid", k_arg0_valid, 0);
        check("rst_k_out0_ready", k_out0_ready, 0);
        check("rst_out0_valid",   out0_valid,   0);
        check("rst_inflight",     inflight,     0);
        check("rst_proto_err",    proto_err,    0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_arg0_ready",   arg0_ready,   1);
        check("post_rst_k_out0_ready", k_out0_ready, 1);
        check("post_rst_out0_valid",   out0_valid,   0);
        check("post_rst_k_arg0_valid", k_arg0_valid, 0);
        @(posedge clk); #1;

        // passthrough with per-cycle latency checks
        push_a(10'h155);
        @(negedge clk);
        check("pt_k_arg0_valid", k_arg0_valid, 1);
        check("pt_k_arg0",       k_arg0,       10'h155);
        check("pt_inflight_0",   inflight,     0);
        @(negedge clk);
        check("pt_inflight_1",   inflight,     1);
        @(negedge clk);
        check("pt_out0_valid",   out0_valid,   1);
        check("pt_inflight_2",   inflight,     0);
        drain_a("pt");

        // credit stall: kernel withholds results
        @(posedge clk); #1;
        ka_hold = 1'b1;
        xfers0 = ka_arg_xfers;
        push_a(10'h0A1);
        push_a(10'h0A2);
        push_a(10'h0A3);
        repeat (3) @(negedge clk);
        check("cs_xfers",        ka_arg_xfers - xfers0, 2);
        check("cs_inflight",     inflight,     2);
        check("cs_k_arg0_valid", k_arg0_valid, 0);
        check("cs_k_arg0_head",  k_arg0,       10'h0A3);
        check("cs_arg0_ready",   arg0_ready,   1);
        @(posedge clk); #1;
        ka_hold = 1'b0;
        drain_a("cs");

        // output backpressure with six tokens
        @(posedge clk); #1;
        out0_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) push_a(10'h301 + 10'(i));
            end
            begin
                repeat (20) @(negedge clk);
                check("bp_out0_valid",   out0_valid,   1);
                check("bp_out0_head",    out0,         10'h301);
                check("bp_inflight",     inflight,     0);
                check("bp_arg0_ready",   arg0_ready,   0);
                check("bp_k_arg0_valid", k_arg0_valid, 0);
                @(posedge clk); #1;
                out0_ready = 1'b1;
            end
        join
        drain_a("bp");

        // stray kernel result
        @(posedge clk); #1;
        ka_inj_data = 10'h3FF;
        ka_inject = 1'b1;
        @(posedge clk); #1;
        ka_inject = 1'b0;
        @(negedge clk);
        check("pe_proto_err",  proto_err,  1);
        check("pe_out0_valid", out0_valid, 0);
        check("pe_inflight",   inflight,   0);
        repeat (5) @(negedge clk);
        check("pe_sticky",     proto_err,  1);
        check("pe_out0_quiet", out0_valid, 0);
        @(posedge clk); #1;
        push_a(10'h2AA);
        drain_a("pe_after");
        check("pe_sticky_after", proto_err, 1);

        // reset mid-stream with one token in each FIFO
        @(posedge clk); #1;
        out0_ready = 1'b0;
        push_a(10'h1E1);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        k_arg0_ready = 1'b0;
        push_a(10'h1E2);
        @(negedge clk);
        check("rm_pre_out0_valid",   out0_valid,   1);
        check("rm_pre_k_arg0_valid", k_arg0_valid, 1);
        #2;
        rst = 1'b1;
        exp_a.delete();
        #1;
        check("rm_out0_valid",   out0_valid,   0);
        check("rm_k_arg0_valid", k_arg0_valid, 0);
        check("rm_inflight",     inflight,     0);
        check("rm_arg0_ready",   arg0_ready,   0);
        check("rm_k_out0_ready", k_out0_ready, 0);
        check("rm_proto_err",    proto_err,    0);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        k_arg0_ready = 1'b1;
        out0_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("rm_after_out0_valid",   out0_valid,   0);
        check("rm_after_k_arg0_valid", k_arg0_valid, 0);
        check("rm_after_arg0_ready",   arg0_ready,   1);
        check("rm_after_k_out0_ready", k_out0_ready, 1);
        @(posedge clk); #1;
        push_a(10'h0F0);
        drain_a("rm_fresh");

        // wide instance: random handshakes over 1000 tokens
        @(posedge clk); #1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(1) == 1) begin
                @(posedge clk); #1;
            end
            push_b($urandom());
        end
        n = 0;
        while ((exp_b.size() != 0 || b_inflight != 3'd0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b_pending",       exp_b.size(),              0);
        check("b_inflight_end",  b_inflight,                0);
        check("b_inflight_le_4", (b_max_inflight <= 4),     1);
        check("b_proto_err",     b_proto_err,               0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/elastic_io_wrapper.md
ELASTIC_IO_WRAPPER -- requirements
Module: elastic_io_wrapper

Interface
REQ-001 The block SHALL have parameter WIDTH, default 10, meaning the data width of argument and result tokens.
REQ-002 The block SHALL have parameter IN_DEPTH, default 2, meaning the number of input FIFO entries (at least 1).
REQ-003 The block SHALL have parameter OUT_DEPTH, default 2, meaning the number of output FIFO entries and kernel credits (at least 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port arg0, input, WIDTH bits: the environment argument token.
REQ-007 The block SHALL have ports arg0_valid (input, 1 bit) and arg0_ready (output, 1 bit): the argument handshake.
REQ-008 The block SHALL have port k_arg0, output, WIDTH bits: the argument token to the kernel.
REQ-009 The block SHALL have ports k_arg0_valid (output, 1 bit) and k_arg0_ready (input, 1 bit): the kernel argument handshake.
REQ-010 The block SHALL have port k_out0, input, WIDTH bits: the result token from the kernel.
REQ-011 The block SHALL have ports k_out0_valid (input, 1 bit) and k_out0_ready (output, 1 bit): the kernel result handshake.
REQ-012 The block SHALL have port out0, output, WIDTH bits: the result token to the environment.
REQ-013 The block SHALL have ports out0_valid (output, 1 bit) and out0_ready (input, 1 bit): the result handshake.
REQ-014 The block SHALL have port inflight, output, clog2(OUT_DEPTH+1) bits: the number of tokens issued to the kernel and not yet returned.
REQ-015 The block SHALL have port proto_err, output, 1 bit: a sticky flag set when the kernel returns a result with no token in flight.

Function
REQ-016 A transfer SHALL occur on a rising clk edge when valid and ready are both 1 on the same channel; data SHALL be held stable while valid=1 and ready=0.
REQ-017 The input FIFO SHALL be registered and first-word-fall-through with 1-cycle latency: an argument accepted at edge N appears on k_arg0/k_arg0_valid after edge N.
REQ-018 arg0_ready SHALL equal "input FIFO not full" and SHALL NOT depend combinationally on k_arg0_ready; when full, a simultaneous pop SHALL NOT admit a push in the same cycle.
REQ-019 k_arg0_valid SHALL be 1 only when the input FIFO is non-empty AND inflight + out_count < OUT_DEPTH (credit available); out_count is the output FIFO occupancy.
REQ-020 inflight SHALL increment on a k_arg0 transfer, decrement on a k_out0 transfer, and remain unchanged when both occur in the same cycle.
REQ-021 k_out0_ready SHALL equal "output FIFO not full"; by construction of REQ-019 it is never 0 while inflight > 0.
REQ-022 The output FIFO SHALL be registered and first-word-fall-through with 1-cycle latency: a result accepted from the kernel at edge N appears on out0/out0_valid after edge N.
REQ-023 out0_ready SHALL only affect the pop; it SHALL have no combinational path to arg0_ready or k_arg0_valid.
REQ-024 Both FIFOs SHALL preserve order; read and write pointers SHALL wrap modulo depth, and a simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged.
REQ-025 proto_err SHALL be set at any edge where k_out0_valid=1 and inflight=0; such a token SHALL be dropped, and proto_err SHALL stay 1 until reset.
REQ-026 Data SHALL pass through unmodified; there SHALL be no width conversion.

Reset
REQ-027 While rst=1, regardless of clk, arg0_ready, k_arg0_valid, k_out0_ready and out0_valid SHALL be 0, inflight SHALL be 0, proto_err SHALL be 0, and all FIFO pointers and occupancy SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight tokens with no partial handshake afterwards.
REQ-029 In the first cycle after rst deasserts, arg0_ready and k_out0_ready SHALL be 1 and all other outputs SHALL be at their reset values.

Verification
REQ-030 Passthrough (defaults, identity kernel model of 1 cycle): arg0=0x155 accepted at edge 1 -> k_arg0_valid at cycle 2; out0=0x155 with out0_valid=1 by cycle 4; inflight returns to 0.
REQ-031 Credit stall: kernel holds results with k_out0_valid=0 and 3 arguments are pushed -> exactly 2 k_arg0 transfers occur, inflight=2, k_arg0_valid=0, and the input FIFO holds the 3rd token.
REQ-032 Output backpressure: out0_ready=0 with a stream of 6 tokens -> output FIFO reaches 2, inflight reaches 0, arg0_ready=0 once the input FIFO is full; releasing out0_ready delivers all 6 tokens in order.
REQ-033 Protocol error: k_out0_valid=1 pulsed for 1 cycle with inflight=0 -> proto_err=1 from the next cycle, out0_valid stays 0, and proto_err clears only on rst.
REQ-034 Reset mid-stream: rst asserted asynchronously between edges while 2 tokens are buffered -> out0_valid and k_arg0_valid fall immediately, inflight=0, and no stale token appears after release.
REQ-035 Parameter sweep with WIDTH=32, IN_DEPTH=1 and OUT_DEPTH=4, random valid/ready at 50% over 1000 tokens -> output order and data equal input, inflight never exceeds 4, and proto_err stays 0.
